gates_selftest_checker: RTL and testbench

//  Synthesizable on-chip stimulus/response checker for the 2-input 'gates' block.
//  - Drives every (a,b) combination in order 00,01,10,11.
//  - Samples the eight gate outputs y[7:0] after a settle delay and compares them

---
 rtl/gates_selftest_checker.sv | 161 ++++++++++++++++
 tb/tb_gates_selftest_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gates_selftest_checker.sv
// ---------------------------------------------------------------------------
// gates_selftest_checker
//   On-chip stimulus/response checker for the 2-input 'gates' block.
//   Sweeps {a,b} through 00,01,10,11 (NUM_PASSES times), waits SETTLE_CYCLES
//   clocks after each drive, then compares y[7:0] against the truth table.
//   Results are reported per vector (fail_vec) and in aggregate (pass,
//   err_count).
//
// Parameters
//   SETTLE_CYCLES  clocks between driving a/b and sampling y (1..15)
//   NUM_PASSES     full sweeps of the 4 vectors per start (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a run when idle
//   y[7:0]     in   gate outputs: AND,OR,NAND,NOR,XOR,XNOR,~a,~b (bit 0..7)
//   a, b       out  stimulus; hold last vector after a run
//   busy       out  high from the cycle after start until done
//   done       out  one-cycle pulse at end of run
//   pass       out  1 = zero mismatches; valid at done, held until next start
//   fail_vec   out  bit i set if vector i={a,b} mismatched in any pass
//   err_count  out  mismatching samples this run, saturating at 255
//
// Optional feature: define GATES_CHECK_CAPTURE_EN to add cap_valid, cap_vec,
//   cap_y, which record the first mismatching sample of a run.
// ---------------------------------------------------------------------------
module gates_selftest_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
`ifdef GATES_CHECK_CAPTURE_EN
    output logic       cap_valid,
    output logic [1:0] cap_vec,
    output logic [7:0] cap_y,
`endif
    output logic [7:0] err_count
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("gates_selftest_checker: SETTLE_CYCLES must be 1..15");
        end
        if (NUM_PASSES < 1 || NUM_PASSES > 15) begin : g_bad_passes
            $error("gates_selftest_checker: NUM_PASSES must be 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, DRIVE, SETTLE, CHECK, FINISH
    } state_t;

    state_t     state;
    logic [1:0] vec_idx;
    logic [3:0] pass_idx;
    logic [3:0] settle_cnt;
    logic [7:0] expected;
    logic       mismatch;

    // Truth table of the block under test for the currently driven vector.
    always_comb begin
        expected = {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    end

    assign mismatch = (y != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_idx    <= 2'd0;
            pass_idx   <= 4'd0;
            settle_cnt <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= 4'd0;
            err_count  <= 8'd0;
`ifdef GATES_CHECK_CAPTURE_EN
            cap_valid  <= 1'b0;
            cap_vec    <= 2'd0;
            cap_y      <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fail_vec  <= 4'd0;
                        err_count <= 8'd0;
                        pass      <= 1'b0;
                        vec_idx   <= 2'd0;
                        pass_idx  <= 4'd0;
                        busy      <= 1'b1;
`ifdef GATES_CHECK_CAPTURE_EN
                        cap_valid <= 1'b0;
                        cap_vec   <= 2'd0;
                        cap_y     <= 8'd0;
`endif
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    {a, b}     <= vec_idx;
                    // Counts down to 0 inclusive, giving SETTLE_CYCLES cycles.
                    settle_cnt <= 4'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) state <= CHECK;
                    else                    settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_vec[vec_idx] <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`ifdef GATES_CHECK_CAPTURE_EN
                        if (!cap_valid) begin
                            cap_valid <= 1'b1;
                            cap_vec   <= vec_idx;
                            cap_y     <= y;
                        end
`endif
                    end
                    if (vec_idx != 2'd3) begin
                        vec_idx <= vec_idx + 2'd1;
                        state   <= DRIVE;
                    end else if (pass_idx != 4'(NUM_PASSES - 1)) begin
                        vec_idx  <= 2'd0;
                        pass_idx <= pass_idx + 4'd1;
                        state    <= DRIVE;
                    end else begin
                        // done/pass are registered here so they are visible
                        // during the FINISH cycle; the final sample's result
                        // is not yet in err_count, hence the extra term.
                        done  <= 1'b1;
                        pass  <= (err_count == 8'd0) && !mismatch;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_selftest_checker.sv
module tb_gates_selftest_checker;

    localparam int S0  = 2;
    localparam int NP0 = 1;
    localparam int L0  = NP0 * 4 * (S0 + 2) + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] fv0, fv1;
    logic [7:0] err0, err1;
`ifdef GATES_CHECK_CAPTURE_EN
    logic       cv0, cv1;
    logic [1:0] cvec0, cvec1;
    logic [7:0] cy0, cy1;
`endif

    // fault masks: stuck-at-0, stuck-at-1, inversion
    logic [7:0] m_s0, m_s1, m_inv, m1_s1;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    gates_selftest_checker #(.SETTLE_CYCLES(S0), .NUM_PASSES(NP0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0),
`ifdef GATES_CHECK_CAPTURE_EN
        .cap_valid(cv0), .cap_vec(cvec0), .cap_y(cy0),
`endif
        .err_count(err0)
    );

    gates_selftest_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1),
`ifdef GATES_CHECK_CAPTURE_EN
        .cap_valid(cv1), .cap_vec(cvec1), .cap_y(cy1),
`endif
        .err_count(err1)
    );

    function automatic logic [7:0] good_y(input logic [1:0] v);
        logic ga, gb;
        ga = v[1];
        gb = v[0];
        return {~gb, ~ga, ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
    endfunction

    function automatic logic [7:0] faulty_y(input logic [1:0] v, input logic [7:0] s0,
                                            input logic [7:0] s1, input logic [7:0] inv);
        return ((good_y(v) & ~s0) | s1) ^ inv;
    endfunction

    always_comb y0 = faulty_y({a0, b0}, m_s0, m_s1, m_inv);
    always_comb y1 = faulty_y({a1, b1}, 8'h00, m1_s1, 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            npass++;
    endtask

    // ---------------- behavioural model of dut0 ----------------
    int         t0 = 0;        // cycle number within run, 0 = idle
    logic       rdone = 1'b0;  // a completed run's results are on the outputs
    logic [1:0] ab_idle = 2'b00;
    logic [3:0] exp_fv;
    int         exp_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0 = 0; rdone = 1'b0; ab_idle = 2'b00;
        end else if (t0 == 0) begin
            if (start0) begin
                t0 = 1; rdone = 1'b0;
                exp_fv = 4'd0; exp_err = 0;
                for (int v = 0; v < 4; v++)
                    if (faulty_y(2'(v), m_s0, m_s1, m_inv) !== good_y(2'(v))) begin
                        exp_fv[v] = 1'b1;
                        exp_err += NP0;
                    end
                if (exp_err > 255) exp_err = 255;
            end
        end else if (t0 == L0) begin
            t0 = 0; ab_idle = 2'b11;
        end else begin
            t0++;
            if (t0 == L0) rdone = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0] eab;
            eab = (t0 >= 2) ? 2'(((t0 - 2) / (S0 + 2)) % 4) : ab_idle;
            chk("busy", busy0, (t0 != 0));
            chk("done", done0, (t0 == L0));
            chk("ab", {a0, b0}, eab);
            if (t0 == 0 || t0 == L0) begin
                chk("pass", pass0, rdone ? (exp_err == 0) : 1'b0);
                chk("fail_vec", fv0, rdone ? exp_fv : 4'd0);
                chk("err_count", err0, rdone ? exp_err : 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Pulses start0 and returns the cycle (1 = first cycle after the start
    // edge) in which done0 is seen; 0 if it never shows within the bound.
    task automatic run0(output int lat, input int repulse_at);
        int n;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        lat = 0;
        while (n < 200) begin
            if (n == repulse_at) start0 = 1'b1;
            else                 start0 = 1'b0;
            if (done0) begin lat = n; break; end
            @(negedge clk);
            n++;
        end
        start0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat, hits;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        m_s0 = 8'h00; m_s1 = 8'h00; m_inv = 8'h00; m1_s1 = 8'h00;
        repeat (3) @(negedge clk);
        // 1: reset state
        chk("rst_a", a0, 1'b0);
        chk("rst_b", b0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_fail_vec", fv0, 4'd0);
        chk("rst_err", err0, 8'd0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_busy", busy0, 1'b0);

        // 2: golden run
        run0(lat, 0);
        chk("golden_latency", lat, 17);
        chk("golden_pass", pass0, 1'b1);
        chk("golden_fail_vec", fv0, 4'b0000);
        chk("golden_err", err0, 8'd0);
        chk("golden_ab_hold", {a0, b0}, 2'b11);

        // 3: y0 stuck-at-0
        m_s0 = 8'h01;
        run0(lat, 0);
        chk("s0_latency", lat, 17);
        chk("s0_fail_vec", fv0, 4'b1000);
        chk("s0_err", err0, 8'd1);
        chk("s0_pass", pass0, 1'b0);
        m_s0 = 8'h00;

        // 5: reset during SETTLE of vector 2
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);   // now in cycle 10, first SETTLE of vector 2
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_ab", {a0, b0}, 2'b00);
        chk("abort_err", err0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) hits++;
        end
        chk("abort_no_done", hits, 0);
        run0(lat, 0);
        chk("after_abort_latency", lat, 17);
        chk("after_abort_pass", pass0, 1'b1);

        // 6: start re-pulsed while busy is ignored
        run0(lat, 5);
        chk("repulse_latency", lat, 17);
        chk("repulse_pass", pass0, 1'b1);
        repeat (3) @(negedge clk);
        chk("repulse_idle", busy0, 1'b0);

`ifdef GATES_CHECK_CAPTURE_EN
        m_inv = 8'h80;
        run0(lat, 0);
        chk("cap_valid", cv0, 1'b1);
        chk("cap_vec", cvec0, 2'b00);
        chk("cap_y", cy0, 8'h6C);
        chk("inv7_fail_vec", fv0, 4'b1111);
        m_inv = 8'h00;
`endif

        // 4: NUM_PASSES=3, y4 stuck-at-1
        m1_s1 = 8'h10;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        for (int n = 1; n < 300; n++) begin
            if (done1) begin lat = n; break; end
            @(negedge clk);
        end
        chk("np3_latency", lat, 49);
        chk("np3_fail_vec", fv1, 4'b1001);
        chk("np3_err", err1, 8'd6);
        chk("np3_pass", pass1, 1'b0);
        @(negedge clk);
        chk("np3_idle", busy1, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
